// File: rtl/sipo_framer.sv
// sipo_framer: serial-in parallel-out word assembler
// with a one-word output register and valid/ready handshake.
module sipo_framer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr_nx;
  logic             last;
  logic             done;

  // Next shift-register value with the incoming bit merged in.
  always_comb begin
    sr_nx = sr;
    if (MSB_FIRST)
      sr_nx = {sr[WIDTH-2:0], din};
    else
      sr_nx = {din, sr[WIDTH-1:1]};
  end

  // A word completes when the final bit of it is sampled.
  always_comb begin
    last = (cnt == CW'(WIDTH - 1));
    done = din_valid && !flush && last;
  end

  assign busy = (state == SHIFT);

  // Shift/count FSM plus output register and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        sr    <= '0;
        cnt   <= '0;
        state <= IDLE;
      end else if (din_valid) begin
        sr <= sr_nx;
        if (last) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt   <= cnt + CW'(1);
          state <= SHIFT;
        end
      end

      if (done) begin
        if (!q_valid || q_ready) begin
          q       <= sr_nx;
          q_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_framer.sv
// tb_sipo_framer: directed bench for sipo_framer,
// one MSB-first and one LSB-first instance on shared inputs.
module tb_sipo_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       flush = 1'b0;
  logic       q_ready = 1'b0;

  logic [3:0] m_q, l_q;
  logic       m_qv, l_qv;
  logic       m_busy, l_busy;
  logic       m_ovf, l_ovf;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sipo_framer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .flush(flush), .q(m_q), .q_valid(m_qv), .q_ready(q_ready),
    .busy(m_busy), .overflow(m_ovf)
  );

  sipo_framer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .flush(flush), .q(l_q), .q_valid(l_qv), .q_ready(q_ready),
    .busy(l_busy), .overflow(l_ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send4(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send(w[i]);
  endtask

  initial begin
    // reset with random serial traffic
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din       = 1'($urandom);
      din_valid = 1'($urandom);
      tick();
    end
    rst       = 1'b0;
    din_valid = 1'b0;
    chk("rst_q", 32'(m_q), 32'h0);
    chk("rst_qv", 32'(m_qv), 32'h0);
    chk("rst_busy", 32'(m_busy), 32'h0);
    chk("rst_ovf", 32'(m_ovf), 32'h0);

    // back-to-back word 1,0,1,1
    q_ready = 1'b1;
    send(1'b1);
    chk("b2b_busy1", 32'(m_busy), 32'h1);
    send(1'b0);
    chk("b2b_busy2", 32'(m_busy), 32'h1);
    send(1'b1);
    chk("b2b_busy3", 32'(m_busy), 32'h1);
    chk("b2b_qv3", 32'(m_qv), 32'h0);
    send(1'b1);
    chk("b2b_q", 32'(m_q), 32'hB);
    chk("b2b_qv", 32'(m_qv), 32'h1);
    chk("b2b_busy4", 32'(m_busy), 32'h0);
    chk("b2b_lsb_q", 32'(l_q), 32'hD);
    tick();
    chk("b2b_qv_clr", 32'(m_qv), 32'h0);
    chk("b2b_q_hold", 32'(m_q), 32'hB);

    // gapped word 0,0,0,1
    send(1'b0);
    tick(); tick();
    chk("gap_busy1", 32'(m_busy), 32'h1);
    send(1'b0);
    tick(); tick();
    chk("gap_busy2", 32'(m_busy), 32'h1);
    send(1'b0);
    tick(); tick();
    chk("gap_busy3", 32'(m_busy), 32'h1);
    chk("gap_q_pre", 32'(m_q), 32'hB);
    chk("gap_qv_pre", 32'(m_qv), 32'h0);
    send(1'b1);
    chk("gap_q", 32'(m_q), 32'h1);
    chk("gap_qv", 32'(m_qv), 32'h1);
    tick();
    chk("gap_qv_clr", 32'(m_qv), 32'h0);

    // overflow with downstream stalled
    q_ready = 1'b0;
    send4(4'b1011);
    chk("ovf_q1", 32'(m_q), 32'hB);
    chk("ovf_qv1", 32'(m_qv), 32'h1);
    chk("ovf_flag0", 32'(m_ovf), 32'h0);
    send4(4'b0010);
    chk("ovf_q2", 32'(m_q), 32'hB);
    chk("ovf_qv2", 32'(m_qv), 32'h1);
    chk("ovf_flag1", 32'(m_ovf), 32'h1);
    tick(); tick();
    chk("ovf_sticky", 32'(m_ovf), 32'h1);

    // same, but ready on the completing edge
    do_rst();
    chk("rr_ovf_rst", 32'(m_ovf), 32'h0);
    chk("rr_q_rst", 32'(m_q), 32'h0);
    send4(4'b1011);
    send(1'b0);
    send(1'b0);
    send(1'b1);
    q_ready = 1'b1;
    send(1'b0);
    q_ready = 1'b0;
    chk("rr_q", 32'(m_q), 32'h2);
    chk("rr_qv", 32'(m_qv), 32'h1);
    chk("rr_ovf", 32'(m_ovf), 32'h0);

    // LSB-first ordering
    do_rst();
    send4(4'b1101);
    chk("lsb_q", 32'(l_q), 32'hB);
    chk("lsb_qv", 32'(l_qv), 32'h1);
    chk("lsb_msb_q", 32'(m_q), 32'hD);

    // flush mid-word while a word is pending and stalled
    send(1'b1);
    send(1'b1);
    din       = 1'b1;
    din_valid = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    din_valid = 1'b0;
    chk("fl_busy", 32'(m_busy), 32'h0);
    chk("fl_qv", 32'(m_qv), 32'h1);
    chk("fl_q", 32'(m_q), 32'hD);
    q_ready = 1'b1;
    send4(4'b0010);
    chk("fl_q2", 32'(m_q), 32'h2);
    chk("fl_qv2", 32'(m_qv), 32'h1);
    chk("fl_ovf", 32'(m_ovf), 32'h0);
    tick();

    // reset mid-word instead of flush
    send(1'b1);
    send(1'b1);
    din       = 1'b1;
    din_valid = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    din_valid = 1'b0;
    chk("rm_busy", 32'(m_busy), 32'h0);
    chk("rm_q", 32'(m_q), 32'h0);
    send4(4'b0010);
    chk("rm_q2", 32'(m_q), 32'h2);
    chk("rm_qv2", 32'(m_qv), 32'h1);
    chk("rm_ovf", 32'(m_ovf), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/sipo_framer.md
SIPO_FRAMER -- requirements
Module: sipo_framer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means the first serial bit received lands in q[WIDTH-1] and 0 means it lands in q[0].
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port din, input, 1 bit: the serial data bit.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din is sampled only when this is high.
REQ-007 The block SHALL have port flush, input, 1 bit: discards any partial word.
REQ-008 The block SHALL have port q, output, WIDTH bits: the assembled parallel word, registered.
REQ-009 The block SHALL have port q_valid, output, 1 bit: q holds an unconsumed word.
REQ-010 The block SHALL have port q_ready, input, 1 bit: the downstream stage accepts q when q_valid and q_ready are both high at a rising edge.
REQ-011 The block SHALL have port busy, output, 1 bit: a partial word (1..WIDTH-1 bits) is held.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag set when a completed word was dropped.

Function
REQ-013 The block SHALL contain a shift register sr[WIDTH-1:0] and a bit counter cnt (0..WIDTH-1), forming a two-state FSM: IDLE (cnt=0) and SHIFT (cnt>0); busy SHALL equal (state==SHIFT).
REQ-014 On an edge with din_valid=1 and flush=0, the block SHALL shift din in: if MSB_FIRST=1, sr <= {sr[WIDTH-2:0],din}; if MSB_FIRST=0, sr <= {din,sr[WIDTH-1:1]}.
REQ-015 On an edge with din_valid=1 and cnt<WIDTH-1, cnt SHALL increment; on an edge with din_valid=1 and cnt=WIDTH-1, the word SHALL complete and cnt SHALL wrap to 0 (FSM to IDLE).
REQ-016 On an edge with din_valid=0, sr and cnt SHALL hold; gaps between bits of any length SHALL be legal.
REQ-017 On word completion, the completed word (sr shifted with the final din) SHALL load into q with q_valid=1 on that same edge if q_valid=0, or if q_valid=1 and q_ready=1 on that edge; latency SHALL be zero cycles after the edge sampling the last bit.
REQ-018 On word completion with q_valid=1 and q_ready=0, the new word SHALL be dropped, q and q_valid SHALL hold, and overflow SHALL be set to 1.
REQ-019 On an edge with q_valid=1, q_ready=1 and no word completing, q_valid SHALL clear and q SHALL retain its last value.
REQ-020 On an edge with flush=1, the block SHALL clear cnt to 0, clear sr to 0, and discard any din on that edge (flush wins over din_valid); q, q_valid and overflow SHALL be unaffected, and the q_ready handshake SHALL proceed normally on that edge.
REQ-021 overflow SHALL be cleared only by rst.
REQ-022 q SHALL change only on a load per REQ-017 or on rst; it SHALL never show a partial word.

Reset
REQ-023 On an edge with rst=1, the block SHALL set q=0, q_valid=0, overflow=0, sr=0, cnt=0 and the FSM to IDLE, overriding every other input on that edge.
REQ-024 A reset asserted mid-word SHALL discard the partial word; the first valid bit after rst deasserts SHALL be bit 0 of a new word.

Verification (WIDTH=4 unless stated)
REQ-025 Bench SHALL drive rst=1 for 2 cycles with random din and din_valid -> q=0000, q_valid=0, busy=0, overflow=0.
REQ-026 Bench SHALL drive MSB_FIRST=1, q_ready=1, serial bits 1,0,1,1 on 4 consecutive edges -> q=1011 and q_valid=1 after the 4th edge, q_valid=0 one edge later, busy=1 after edges 1-3.
REQ-027 Bench SHALL drive bits 0,0,0,1 with din_valid low for 2 cycles between each bit -> busy stays 1 through the gaps, q=0001 only after the 4th valid bit.
REQ-028 Bench SHALL drive q_ready=0 with words 1011 then 0010 -> q stays 1011 and overflow=1 after the 8th bit; repeating after reset with q_ready=1 on the 8th edge only -> q=0010, q_valid=1, overflow=0.
REQ-029 Bench SHALL set MSB_FIRST=0 and drive bits 1,1,0,1 -> q=1011.
REQ-030 Bench SHALL drive bits 1,1, then flush=1 together with din_valid=1, then bits 0,0,1,0 -> q=0010; repeating with rst in place of flush -> same q, overflow=0.
